// File: rtl/mem_pkg.sv
// Shared types for the memory-stage access unit.
//   acc_t     : decoded access width/sign class
//   mstate_t  : access FSM states
//   wreg_t    : M->W pipeline register contents
//   decode_acc: maps instruction class bits + byte enables to acc_t
package mem_pkg;

  localparam int MEM_TIMEOUT_DEF = 64;
  localparam int NUM_LANES       = 4;   // byte lanes per 32-bit word

  typedef enum logic [2:0] {NONE, WORD, BYTE, HALF, SBYTE, SHALF} acc_t;

  typedef enum logic [1:0] {IDLE, WAIT, ERR} mstate_t;

  typedef struct packed {
    logic        pcsrc;
    logic        regwrite;
    logic        memtoreg;
    logic        memerr;
    logic [3:0]  rd;
    logic [31:0] aluout;
    logic [31:0] readdata;
  } wreg_t;

  // Class 01 is the word/unsigned-byte family (width from byte enables),
  // class 00 is the halfword/signed family (width from op bits 6:5).
  function automatic acc_t decode_acc(input logic [1:0] cls,
                                      input logic [1:0] op,
                                      input logic [3:0] be);
    acc_t t;
    t = NONE;
    if (cls == 2'b01) begin
      if (be == 4'b1111)
        t = WORD;
      else if (be == 4'b0001 || be == 4'b0010 || be == 4'b0100 || be == 4'b1000)
        t = BYTE;
    end else if (cls == 2'b00) begin
      case (op)
        2'b01:   t = HALF;
        2'b10:   t = SBYTE;
        2'b11:   t = SHALF;
        default: t = NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data alignment: picks the byte or halfword lane out of
// the returned memory word and zero/sign extends it to 32 bits.
//   atype   : decoded access type
//   addr_lo : low address bits (lane select; bit 0 ignored for halfwords)
//   rdata   : raw word from data memory
//   data    : extracted, extended load value
module load_extract
  import mem_pkg::*;
(
  input  acc_t        atype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [7:0]                b;
  logic [15:0]               h;

  assign lanes = rdata;
  assign b     = lanes[addr_lo];
  assign h     = addr_lo[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

  always_comb begin
    case (atype)
      BYTE:    data = {24'd0, b};
      SBYTE:   data = {{24{b[7]}}, b};
      HALF:    data = {16'd0, h};
      SHALF:   data = {{16{h[15]}}, h};
      default: data = rdata;   // WORD (and undecodable) pass through
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage of the pipeline: issues data-memory accesses, stalls the
// front of the pipe while memory is slow, times out hung accesses and
// registers the M->W pipeline state.
//   clk, reset        : clock, async active-high reset
//   *M inputs         : memory-stage controls, address, store data, decode bits
//   mem_* outputs     : request, write, aligned address, lane-replicated data, lane enables
//   mem_ready/rdata   : memory handshake / read data
//   StallM            : freeze F/D/E/M while an access is outstanding
//   *W outputs        : writeback register contents, MemErrW flags a timed-out access
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [3:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  Instr27_26M,
  input  logic [1:0]  Instr6_5M,
  input  logic [3:0]  byteEnableM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [3:0]  RdW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic        MemErrW
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  acc_t          atype;
  logic          active;
  mstate_t       state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic          req, stall, abort;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   ld_data;
  wreg_t         wreg, wreg_nx;

  assign active = MemtoRegM | MemWriteM;
  assign atype  = decode_acc(Instr27_26M, Instr6_5M, byteEnableM);

  // Lane enables and store-data replication. Halfwords ignore addr[0]
  // (misalignment is silently rounded, never faulted).
  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    case (atype)
      BYTE, SBYTE: begin
        be    = 4'b0001 << ALUResultM[1:0];
        wdata = {4{WriteDataM[7:0]}};
      end
      HALF, SHALF: begin
        be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  load_extract u_ext (
    .atype   (atype),
    .addr_lo (ALUResultM[1:0]),
    .rdata   (mem_rdata),
    .data    (ld_data)
  );

  // Access FSM. The pipe is frozen while stalled, so the M inputs (and hence
  // the request fields derived from them) stay stable across WAIT.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    req      = 1'b0;
    stall    = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (active) begin
          req = 1'b1;
          if (!mem_ready) begin
            stall    = 1'b1;
            state_nx = WAIT;
            wcnt_nx  = '0;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (mem_ready) begin
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
          // wcnt holds WAIT cycles already spent; this is the last allowed one
          if (wcnt == CW'(MEM_TIMEOUT - 1)) begin
            state_nx = ERR;
            wcnt_nx  = '0;
          end else begin
            wcnt_nx = wcnt + 1'b1;
          end
        end
      end
      ERR: begin
        abort    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset must kill the request/stall immediately, not at the next edge.
  assign mem_req   = req & ~reset;
  assign StallM    = stall & ~reset;
  assign mem_we    = mem_req & MemWriteM;
  assign mem_addr  = mem_req ? {ALUResultM[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = mem_req ? wdata : '0;

  // W register: bubble while stalled, error marker after a timeout,
  // otherwise capture the M stage. ReadDataW only moves on a load.
  always_comb begin
    wreg_nx        = wreg;
    wreg_nx.memerr = 1'b0;
    if (stall) begin
      wreg_nx.pcsrc    = 1'b0;
      wreg_nx.regwrite = 1'b0;
      wreg_nx.memtoreg = 1'b0;
    end else if (abort) begin
      wreg_nx.pcsrc    = 1'b0;
      wreg_nx.regwrite = 1'b0;
      wreg_nx.memtoreg = 1'b0;
      wreg_nx.memerr   = 1'b1;
      wreg_nx.rd       = RdM;
      wreg_nx.aluout   = ALUResultM;
    end else begin
      wreg_nx.pcsrc    = PCSrcM;
      wreg_nx.regwrite = RegWriteM;
      wreg_nx.memtoreg = MemtoRegM;
      wreg_nx.rd       = RdM;
      wreg_nx.aluout   = ALUResultM;
      if (MemtoRegM) wreg_nx.readdata = ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
      wreg  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      wreg  <= wreg_nx;
    end
  end

  assign PCSrcW    = wreg.pcsrc;
  assign RegWriteW = wreg.regwrite;
  assign MemtoRegW = wreg.memtoreg;
  assign MemErrW   = wreg.memerr;
  assign RdW       = wreg.rd;
  assign ALUOutW   = wreg.aluout;
  assign ReadDataW = wreg.readdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a random
// back-to-back stream, checked against an arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [1:0]  Instr27_26M, Instr6_5M;
  logic [3:0]  byteEnableM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [3:0]  RdW;
  logic [31:0] ALUOutW, ReadDataW;
  logic        MemErrW;

  mem_access_unit #(.MEM_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .Instr27_26M(Instr27_26M), .Instr6_5M(Instr6_5M), .byteEnableM(byteEnableM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .StallM(StallM),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .RdW(RdW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .MemErrW(MemErrW)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  localparam int K_LDR = 0, K_LDRB = 1, K_LDRH = 2, K_LDRSB = 3, K_LDRSH = 4;
  localparam int K_STR = 5, K_STRB = 6, K_STRH = 7, K_ALU = 8;

  logic [31:0] exp_rdw;   // value ReadDataW must currently show

  // ---------------- reference model ----------------
  function automatic int k_size(input int k);
    if (k == K_LDRB || k == K_LDRSB || k == K_STRB) return 1;
    if (k == K_LDRH || k == K_LDRSH || k == K_STRH) return 2;
    return 4;
  endfunction

  function automatic bit k_load(input int k);
    return k <= K_LDRSH;
  endfunction

  function automatic bit k_store(input int k);
    return k >= K_STR && k <= K_STRH;
  endfunction

  function automatic logic [31:0] m_load(input int k, input logic [31:0] a, input logic [31:0] rd);
    longint unsigned r, v, span;
    int sz, off;
    sz = k_size(k);
    if (sz == 4) return rd;
    off  = (sz == 1) ? int'(a % 4) : 2 * int'((a % 4) / 2);
    span = 64'd1 << (8 * sz);
    r    = 64'(rd);
    v    = (r >> (8 * off)) % span;
    if ((k == K_LDRSB || k == K_LDRSH) && v >= span / 2)
      v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input int k, input logic [31:0] a);
    int sz;
    sz = k_size(k);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (2 * ((a % 4) / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int k, input logic [31:0] wd);
    longint unsigned v;
    int sz;
    sz = k_size(k);
    v  = 64'(wd);
    if (sz == 1) v = (v % 256) * 64'h0101_0101;
    else if (sz == 2) v = (v % 65536) * 64'h0001_0001;
    return v[31:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic set_instr(input int k, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] rd, input logic pc);
    PCSrcM      = pc;
    RegWriteM   = k_load(k) || k == K_ALU;
    MemtoRegM   = k_load(k);
    MemWriteM   = k_store(k);
    RdM         = rd;
    ALUResultM  = a;
    WriteDataM  = wd;
    Instr6_5M   = 2'b00;
    byteEnableM = 4'hF;
    if (k == K_LDR || k == K_STR) Instr27_26M = 2'b01;
    else if (k == K_LDRB || k == K_STRB) begin
      Instr27_26M = 2'b01;
      byteEnableM = 4'(1 << (a % 4));
    end else begin
      Instr27_26M = 2'b00;
      if (k == K_LDRH || k == K_STRH) Instr6_5M = 2'b01;
      if (k == K_LDRSB) Instr6_5M = 2'b10;
      if (k == K_LDRSH) Instr6_5M = 2'b11;
    end
  endtask

  // Runs one M-stage instruction from a negedge until StallM is low at a
  // posedge; ready arrives 'delay' cycles in (negative = never).
  // Returns observations; time on exit is 1 unit after that posedge.
  task automatic run_access(input int delay, input logic [31:0] rdata,
                            output int stalls, output logic f_req, output logic f_we,
                            output logic [31:0] f_addr, output logic [31:0] f_wdata,
                            output logic [3:0] f_be, output bit held_bad,
                            output bit bubble_bad, output logic l_req);
    int cyc;
    logic st;
    cyc = 0; stalls = 0; held_bad = 0; bubble_bad = 0;
    f_req = 0; f_we = 0; f_addr = 0; f_wdata = 0; f_be = 0; l_req = 0;
    while (1) begin
      mem_ready = (cyc == delay);
      mem_rdata = (cyc == delay) ? rdata : $urandom;
      #1;
      st = StallM;
      if (cyc == 0) begin
        f_req = mem_req; f_we = mem_we; f_addr = mem_addr; f_wdata = mem_wdata; f_be = mem_be;
      end else if (mem_req === 1'b1 &&
                   (mem_we !== f_we || mem_addr !== f_addr || mem_wdata !== f_wdata || mem_be !== f_be))
        held_bad = 1;
      l_req = mem_req;
      @(posedge clk); #1;
      if (st !== 1'b1) break;
      stalls++;
      if (RegWriteW !== 1'b0 || PCSrcW !== 1'b0 || MemtoRegW !== 1'b0 || MemErrW !== 1'b0)
        bubble_bad = 1;
      cyc++;
      if (cyc > 200) begin
        stalls = -1;
        break;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_instr(K_LDR, 32'h40, 32'h0, 4'd3, 1'b1);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || StallM !== 1'b0) begin
      errs++; $display("FAIL reset_req_stall: got req=%b stall=%b want 0 0", mem_req, StallM);
    end
    vectors++;
    if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, RdW, ALUOutW, ReadDataW} !== '0) begin
      errs++; $display("FAIL reset_w: got rd=%h alu=%h rdata=%h ctl=%b%b%b%b want all 0",
                       RdW, ALUOutW, ReadDataW, PCSrcW, RegWriteW, MemtoRegW, MemErrW);
    end
    @(negedge clk);
    set_instr(K_ALU, 32'h0, 32'h0, 4'd0, 1'b0);
    reset = 1'b0;
    exp_rdw = 32'h0;
  endtask

  task automatic test_ldr_fast();
    int st; logic fr, fw, lr; logic [31:0] fa, fd; logic [3:0] fb; bit hb, bb;
    @(negedge clk);
    set_instr(K_LDR, 32'h100, 32'h0, 4'd5, 1'b0);
    run_access(0, 32'hDEADBEEF, st, fr, fw, fa, fd, fb, hb, bb, lr);
    exp_rdw = 32'hDEADBEEF;
    vectors++;
    if (st !== 0) begin errs++; $display("FAIL ldr_fast_stall: got %0d stall cycles want 0", st); end
    vectors++;
    if (fr !== 1'b1 || fw !== 1'b0 || fa !== 32'h100 || fb !== 4'hF) begin
      errs++; $display("FAIL ldr_fast_req: got req=%b we=%b addr=%h be=%b want 1 0 00000100 1111", fr, fw, fa, fb);
    end
    vectors++;
    if (ReadDataW !== 32'hDEADBEEF || RegWriteW !== 1'b1 || MemtoRegW !== 1'b1 || RdW !== 4'd5) begin
      errs++; $display("FAIL ldr_fast_w: got rdata=%h rw=%b m2r=%b rd=%0d want deadbeef 1 1 5",
                       ReadDataW, RegWriteW, MemtoRegW, RdW);
    end
  endtask

  task automatic test_ldrsb_wait();
    int st; logic fr, fw, lr; logic [31:0] fa, fd; logic [3:0] fb; bit hb, bb;
    @(negedge clk);
    set_instr(K_LDRSB, 32'h103, 32'h0, 4'd7, 1'b0);
    run_access(3, 32'h80000000, st, fr, fw, fa, fd, fb, hb, bb, lr);
    exp_rdw = 32'hFFFFFF80;
    vectors++;
    if (st !== 3) begin errs++; $display("FAIL ldrsb_stall: got %0d stall cycles want 3", st); end
    vectors++;
    if (bb || hb) begin errs++; $display("FAIL ldrsb_bubble_hold: got bubble_bad=%0d held_bad=%0d want 0 0", bb, hb); end
    vectors++;
    if (fa !== 32'h100 || fb !== 4'b1000) begin
      errs++; $display("FAIL ldrsb_req: got addr=%h be=%b want 00000100 1000", fa, fb);
    end
    vectors++;
    if (ReadDataW !== exp_rdw || RegWriteW !== 1'b1) begin
      errs++; $display("FAIL ldrsb_data: got %h rw=%b want %h 1", ReadDataW, RegWriteW, exp_rdw);
    end
  endtask

  task automatic test_strh();
    int st; logic fr, fw, lr; logic [31:0] fa, fd; logic [3:0] fb; bit hb, bb;
    @(negedge clk);
    set_instr(K_STRH, 32'h202, 32'h1234ABCD, 4'd2, 1'b0);
    run_access(int'($urandom_range(0, 2)), 32'h5555AAAA, st, fr, fw, fa, fd, fb, hb, bb, lr);
    vectors++;
    if (fr !== 1'b1 || fw !== 1'b1 || fa !== 32'h200 || fb !== 4'b1100 || fd !== 32'hABCDABCD) begin
      errs++; $display("FAIL strh_req: got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000200 1100 abcdabcd",
                       fr, fw, fa, fb, fd);
    end
    vectors++;
    if (ReadDataW !== exp_rdw || RegWriteW !== 1'b0 || hb) begin
      errs++; $display("FAIL strh_w: got rdata=%h rw=%b held_bad=%0d want %h 0 0", ReadDataW, RegWriteW, hb, exp_rdw);
    end
  endtask

  task automatic test_halfword();
    int st; logic fr, fw, lr; logic [31:0] fa, fd; logic [3:0] fb; bit hb, bb;
    logic [31:0] rd;
    rd = {16'h8001, 16'($urandom)};
    @(negedge clk);
    set_instr(K_LDRH, 32'h006, 32'h0, 4'd9, 1'b0);
    run_access(1, rd, st, fr, fw, fa, fd, fb, hb, bb, lr);
    vectors++;
    if (ReadDataW !== 32'h00008001 || fb !== 4'b1100 || fa !== 32'h4) begin
      errs++; $display("FAIL ldrh: got %h be=%b addr=%h want 00008001 1100 00000004", ReadDataW, fb, fa);
    end
    @(negedge clk);
    set_instr(K_LDRSH, 32'h006, 32'h0, 4'd9, 1'b0);
    run_access(0, rd, st, fr, fw, fa, fd, fb, hb, bb, lr);
    exp_rdw = 32'hFFFF8001;
    vectors++;
    if (ReadDataW !== 32'hFFFF8001) begin
      errs++; $display("FAIL ldrsh: got %h want ffff8001", ReadDataW);
    end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    set_instr(K_ALU, 32'hCAFE0011, 32'h0, 4'd12, 1'b1);
    mem_ready = 1'b1;       // must be ignored without a request
    mem_rdata = 32'h13572468;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || StallM !== 1'b0) begin
      errs++; $display("FAIL pass_req: got req=%b stall=%b want 0 0", mem_req, StallM);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    vectors++;
    if (ALUOutW !== 32'hCAFE0011 || RdW !== 4'd12 || RegWriteW !== 1'b1 || PCSrcW !== 1'b1 ||
        MemtoRegW !== 1'b0 || ReadDataW !== exp_rdw) begin
      errs++; $display("FAIL pass_w: got alu=%h rd=%0d rw=%b pc=%b m2r=%b rdata=%h want cafe0011 12 1 1 0 %h",
                       ALUOutW, RdW, RegWriteW, PCSrcW, MemtoRegW, ReadDataW, exp_rdw);
    end
  endtask

  task automatic test_timeout();
    int st; logic fr, fw, lr; logic [31:0] fa, fd; logic [3:0] fb; bit hb, bb;
    @(negedge clk);
    set_instr(K_LDR, 32'h300, 32'h0, 4'd4, 1'b1);
    run_access(-1, 32'h0, st, fr, fw, fa, fd, fb, hb, bb, lr);
    vectors++;
    if (st !== 65 || bb) begin
      errs++; $display("FAIL timeout_stall: got %0d stall cycles bubble_bad=%0d want 65 0", st, bb);
    end
    vectors++;
    if (lr !== 1'b0) begin errs++; $display("FAIL timeout_err_req: got req=%b in error cycle want 0", lr); end
    vectors++;
    if (MemErrW !== 1'b1 || RegWriteW !== 1'b0 || PCSrcW !== 1'b0 || ReadDataW !== exp_rdw) begin
      errs++; $display("FAIL timeout_w: got err=%b rw=%b pc=%b rdata=%h want 1 0 0 %h",
                       MemErrW, RegWriteW, PCSrcW, ReadDataW, exp_rdw);
    end
    @(negedge clk);
    set_instr(K_ALU, 32'h1, 32'h0, 4'd1, 1'b0);
    #1;
    vectors++;
    if (StallM !== 1'b0) begin errs++; $display("FAIL timeout_release: got stall=%b want 0", StallM); end
    @(posedge clk); #1;
    vectors++;
    if (MemErrW !== 1'b0) begin errs++; $display("FAIL timeout_err_len: got err=%b want 0", MemErrW); end
  endtask

  task automatic test_reset_in_wait();
    int st; logic fr, fw, lr; logic [31:0] fa, fd; logic [3:0] fb; bit hb, bb;
    @(negedge clk);
    set_instr(K_LDR, 32'h480, 32'h0, 4'd6, 1'b0);
    mem_ready = 1'b0;
    @(posedge clk);     // IDLE -> WAIT
    @(posedge clk);     // first WAIT cycle done
    @(negedge clk);     // second WAIT cycle
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || StallM !== 1'b0) begin
      errs++; $display("FAIL rstwait_req: got req=%b stall=%b want 0 0", mem_req, StallM);
    end
    vectors++;
    if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, RdW, ALUOutW, ReadDataW} !== '0) begin
      errs++; $display("FAIL rstwait_w: got alu=%h rdata=%h err=%b want all 0", ALUOutW, ReadDataW, MemErrW);
    end
    exp_rdw = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    // a fresh hung access must take the full budget again: FSM back in IDLE, counter cleared
    run_access(-1, 32'h0, st, fr, fw, fa, fd, fb, hb, bb, lr);
    vectors++;
    if (st !== 65 || MemErrW !== 1'b1) begin
      errs++; $display("FAIL rstwait_restart: got %0d stall cycles err=%b want 65 1", st, MemErrW);
    end
  endtask

  task automatic test_random_back_to_back();
    int st; logic fr, fw, lr; logic [31:0] fa, fd; logic [3:0] fb; bit hb, bb;
    int k, dly; logic [31:0] a, wd, rd; logic [3:0] rdn; logic pc; bit acc;
    for (int i = 0; i < 40; i++) begin
      k   = int'($urandom_range(0, 8));
      a   = $urandom; wd = $urandom; rd = $urandom; rdn = 4'($urandom); pc = 1'($urandom);
      dly = int'($urandom_range(0, 4));
      acc = (k != K_ALU);
      @(negedge clk);
      set_instr(k, a, wd, rdn, pc);
      run_access(acc ? dly : 0, rd, st, fr, fw, fa, fd, fb, hb, bb, lr);
      if (k_load(k)) exp_rdw = m_load(k, a, rd);
      vectors++;
      if (st !== (acc ? dly : 0) || hb || bb) begin
        errs++; $display("FAIL rnd%0d_stall: kind=%0d got stalls=%0d held_bad=%0d bubble_bad=%0d want %0d 0 0",
                         i, k, st, hb, bb, acc ? dly : 0);
      end
      vectors++;
      if (fr !== acc || (acc && (fa !== {a[31:2], 2'b00} || fb !== m_be(k, a) || fw !== k_store(k)))) begin
        errs++; $display("FAIL rnd%0d_req: kind=%0d got req=%b addr=%h be=%b we=%b want %b %h %b %b",
                         i, k, fr, fa, fb, fw, acc, {a[31:2], 2'b00}, m_be(k, a), k_store(k));
      end
      if (k_store(k)) begin
        vectors++;
        if (fd !== m_wdata(k, wd)) begin
          errs++; $display("FAIL rnd%0d_wdata: kind=%0d got %h want %h", i, k, fd, m_wdata(k, wd));
        end
      end
      vectors++;
      if (ReadDataW !== exp_rdw || ALUOutW !== a || RdW !== rdn || PCSrcW !== pc ||
          RegWriteW !== (k_load(k) || k == K_ALU) || MemtoRegW !== k_load(k) || MemErrW !== 1'b0) begin
        errs++; $display("FAIL rnd%0d_w: kind=%0d got rdata=%h alu=%h rd=%0d pc=%b rw=%b m2r=%b want %h %h %0d %b %b %b",
                         i, k, ReadDataW, ALUOutW, RdW, PCSrcW, RegWriteW, MemtoRegW,
                         exp_rdw, a, rdn, pc, k_load(k) || k == K_ALU, k_load(k));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_ldr_fast();
    test_ldrsb_wait();
    test_strh();
    test_halfword();
    test_passthrough();
    test_timeout();
    test_reset_in_wait();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have the following parameter: MEM_TIMEOUT, default 64, maximum wait cycles allowed for mem_ready.
REQ-002 The module SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  in  1 each  memory-stage controls.
- RdM  in  4  destination register.
- ALUResultM  in  32  access address / ALU result.
- WriteDataM  in  32  store data.
- Instr27_26M, Instr6_5M  in  2 each  instruction class / halfword-signed select.
- byteEnableM  in  4  1111 = word, one-hot = byte.
- mem_req, mem_we  out  1 each  data-memory request / write.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  lane enables.
- mem_ready  in  1  access complete.
- mem_rdata  in  32  read data.
- StallM  out  1  freeze F/D/E/M to hazard unit.
- PCSrcW, RegWriteW, MemtoRegW  out  1 each  writeback controls.
- RdW  out  4  writeback register.
- ALUOutW, ReadDataW  out  32 each  writeback values.
- MemErrW  out  1  access timed out.

Function
REQ-003 An access SHALL be active when MemtoRegM or MemWriteM is 1; with neither set, the stage SHALL pass through in one cycle with no request.
REQ-004 The access type SHALL be decoded from Instr27_26M and byteEnableM:
- Instr27_26M=01 and byteEnableM=1111 SHALL decode as WORD.
- Instr27_26M=01 and byteEnableM one-hot SHALL decode as BYTE.
- Instr27_26M=00 with Instr6_5M=01 SHALL decode as HALF (unsigned).
- Instr27_26M=00 with Instr6_5M=10 SHALL decode as SBYTE.
- Instr27_26M=00 with Instr6_5M=11 SHALL decode as SHALF.
REQ-005 mem_addr SHALL be {ALUResultM[31:2],2'b00}; misalignment SHALL NOT fault: HALF/SHALF SHALL ignore addr[0].
REQ-006 mem_be SHALL be 1111 for WORD, 0001<<addr[1:0] for byte types, and 0011 or 1100 for halfwords, selected by addr[1].
REQ-007 mem_wdata SHALL carry byte stores replicated x4 and halfword stores replicated x2.
REQ-008 The FSM SHALL have the states IDLE, WAIT and ERR.
REQ-009 In IDLE with an active access, mem_req SHALL assert in the same cycle; if mem_ready=1 in that cycle the access SHALL complete with zero stall.
REQ-010 In IDLE with an active access and mem_ready=0, the FSM SHALL move to WAIT, StallM SHALL be 1 combinationally, and mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable until mem_ready.
REQ-011 In WAIT, on mem_ready=1 the access SHALL complete, StallM SHALL drop in that cycle, and the FSM SHALL return to IDLE.
REQ-012 A wait counter SHALL count cycles in WAIT; on reaching MEM_TIMEOUT it SHALL abort the access and move to ERR.
REQ-013 ERR SHALL last one cycle: mem_req=0, StallM=0, MemErrW=1 on the next W update, RegWriteW=0, PCSrcW=0; the FSM SHALL then return to IDLE.
REQ-014 The load result SHALL be taken from mem_rdata with the lane selected by addr[1:0]; HALF and BYTE SHALL be zero-extended, SHALF and SBYTE sign-extended, and WORD passed unchanged.
REQ-015 The W register SHALL update every cycle.
REQ-016 On completion, the W register SHALL take the M controls, RdM, ALUResultM and the extracted data.
REQ-017 While StallM=1, the W register SHALL take a bubble: RegWriteW=0, PCSrcW=0, MemtoRegW=0, MemErrW=0.
REQ-018 mem_ready while mem_req=0 SHALL be ignored.
REQ-019 A store SHALL never update ReadDataW; it SHALL hold its previous value.

Reset
REQ-020 reset SHALL force the FSM to IDLE and clear the wait counter.
REQ-021 reset SHALL clear mem_req and StallM immediately, asynchronously.
REQ-022 reset SHALL clear all W outputs to 0.
REQ-023 A reset during WAIT SHALL abandon the access with no W update and no MemErrW.

Structure
REQ-024 Package mem_pkg SHALL hold the access-type enum (NONE, WORD, BYTE, HALF, SBYTE, SHALF), the FSM state enum and the MEM_TIMEOUT default.
REQ-025 The sub-module load_extract SHALL be combinational and SHALL perform lane select and extension.
REQ-026 The top level SHALL contain the decode, FSM, counter and W register.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- LDR at 0x100, mem_ready same cycle, rdata=0xDEADBEEF -> StallM never 1; next edge ReadDataW=0xDEADBEEF, RegWriteW=1.
- LDRSB at 0x103, rdata=0x80000000, ready after 3 cycles -> StallM=1 for 3 cycles, W bubbles, then ReadDataW=0xFFFFFF80.
- STRH at 0x202, WriteDataM=0x1234ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
- LDRH at 0x006, rdata=0x8001xxxx -> ReadDataW=0x00008001; LDRSH at the same address -> 0xFFFF8001.
- mem_ready held 0 -> after 64 WAIT cycles, MemErrW=1 for one cycle, RegWriteW=0, StallM released.
- reset asserted in the 2nd WAIT cycle -> mem_req=0 and StallM=0 immediately, W outputs 0, FSM IDLE.
